// File: rtl/register_bank.sv
// register_bank: 32 x 32-bit general-purpose register file for the multicycle MIPS datapath.
// Register 0 always reads 0. Register 29 ($sp) loads SP_RESET on reset. The block also holds
// the A/B operand latches that feed the ALU-source selectors.
//
// Ports:
//   clk           - system clock; all state changes on the rising edge
//   reset         - synchronous active-high reset; overrides reg_write_i and ab_load_i
//   reg_write_i   - write enable
//   write_reg_i   - destination register; only bits [4:0] are used
//   write_data_i  - value to write
//   read_reg1_i   - read port 1 address (rs)
//   read_reg2_i   - read port 2 address (rt)
//   ab_load_i     - load enable for reg_a_o / reg_b_o
//   read_data1_o  - combinational port 1 data (forwarded when BYPASS = 1)
//   read_data2_o  - combinational port 2 data (forwarded when BYPASS = 1)
//   reg_a_o       - registered copy of read_data1_o
//   reg_b_o       - registered copy of read_data2_o
//   dbg_addr_i    - debug read address
//   dbg_data_o    - debug read data; always the stored value, never forwarded
module register_bank #(
    parameter int unsigned SP_RESET = 227,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        reg_write_i,
    input  logic [31:0] write_reg_i,
    input  logic [31:0] write_data_i,
    input  logic [4:0]  read_reg1_i,
    input  logic [4:0]  read_reg2_i,
    input  logic        ab_load_i,
    output logic [31:0] read_data1_o,
    output logic [31:0] read_data2_o,
    output logic [31:0] reg_a_o,
    output logic [31:0] reg_b_o,
    input  logic [4:0]  dbg_addr_i,
    output logic [31:0] dbg_data_o
);

    localparam int unsigned SpIdx = 29;

    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];
    logic [31:0] reg_a_q, reg_a_d;
    logic [31:0] reg_b_q, reg_b_d;
    logic [4:0]  waddr;
    logic        wr_en;

    // The write-register selector drives a full word; the upper bits carry no meaning here.
    logic unused_write_reg_hi;
    assign unused_write_reg_hi = ^write_reg_i[31:5];

    assign waddr = write_reg_i[4:0];
    // Writes to $zero are dropped so entry 0 stays 0 in storage.
    assign wr_en = reg_write_i && (waddr != 5'd0);

    // Read ports: address 0 forced to 0, then optional same-cycle forwarding of the write.
    always_comb begin
        read_data1_o = regs_q[read_reg1_i];
        if (read_reg1_i == 5'd0) begin
            read_data1_o = '0;
        end else if (BYPASS && wr_en && (read_reg1_i == waddr)) begin
            read_data1_o = write_data_i;
        end
    end

    always_comb begin
        read_data2_o = regs_q[read_reg2_i];
        if (read_reg2_i == 5'd0) begin
            read_data2_o = '0;
        end else if (BYPASS && wr_en && (read_reg2_i == waddr)) begin
            read_data2_o = write_data_i;
        end
    end

    always_comb begin
        dbg_data_o = regs_q[dbg_addr_i];
        if (dbg_addr_i == 5'd0) begin
            dbg_data_o = '0;
        end
    end

    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[waddr] = write_data_i;
        end
    end

    // Latches capture the read-port values, so forwarding carries through to them.
    always_comb begin
        reg_a_d = reg_a_q;
        reg_b_d = reg_b_q;
        if (ab_load_i) begin
            reg_a_d = read_data1_o;
            reg_b_d = read_data2_o;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= (i == SpIdx) ? 32'(SP_RESET) : 32'd0;
            end
            reg_a_q <= '0;
            reg_b_q <= '0;
        end else begin
            regs_q  <= regs_d;
            reg_a_q <= reg_a_d;
            reg_b_q <= reg_b_d;
        end
    end

    assign reg_a_o = reg_a_q;
    assign reg_b_o = reg_b_q;

endmodule

// File: tb/tb_register_bank.sv
module tb_register_bank;

    logic        clk = 1'b0;
    logic        reset;
    logic        reg_write;
    logic [31:0] write_reg;
    logic [31:0] write_data;
    logic [4:0]  read_reg1;
    logic [4:0]  read_reg2;
    logic        ab_load;
    logic [4:0]  dbg_addr;

    logic [31:0] b_rd1, b_rd2, b_a, b_b, b_dbg;   // BYPASS = 1 instance
    logic [31:0] n_rd1, n_rd2, n_a, n_b, n_dbg;   // BYPASS = 0 instance

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    register_bank #(.SP_RESET(227), .BYPASS(1'b1)) u_byp (
        .clk          (clk),
        .reset        (reset),
        .reg_write_i  (reg_write),
        .write_reg_i  (write_reg),
        .write_data_i (write_data),
        .read_reg1_i  (read_reg1),
        .read_reg2_i  (read_reg2),
        .ab_load_i    (ab_load),
        .read_data1_o (b_rd1),
        .read_data2_o (b_rd2),
        .reg_a_o      (b_a),
        .reg_b_o      (b_b),
        .dbg_addr_i   (dbg_addr),
        .dbg_data_o   (b_dbg)
    );

    register_bank #(.SP_RESET(227), .BYPASS(1'b0)) u_nob (
        .clk          (clk),
        .reset        (reset),
        .reg_write_i  (reg_write),
        .write_reg_i  (write_reg),
        .write_data_i (write_data),
        .read_reg1_i  (read_reg1),
        .read_reg2_i  (read_reg2),
        .ab_load_i    (ab_load),
        .read_data1_o (n_rd1),
        .read_data2_o (n_rd2),
        .reg_a_o      (n_a),
        .reg_b_o      (n_b),
        .dbg_addr_i   (dbg_addr),
        .dbg_data_o   (n_dbg)
    );

    // Reference model: plain array plus the four latch values.
    logic [31:0] mem [32];
    logic [31:0] ma_b, mb_b, ma_n, mb_n;

    function automatic logic [31:0] mread(input logic [4:0] addr, input bit byp);
        if (addr == 5'd0) return 32'd0;
        if (byp && reg_write && (write_reg % 32 == 32'(addr))) return write_data;
        return mem[addr];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rst, input logic rw, input logic [31:0] wreg,
                         input logic [31:0] wd, input logic [4:0] r1, input logic [4:0] r2,
                         input logic ab, input logic [4:0] dbg);
        reset = rst; reg_write = rw; write_reg = wreg; write_data = wd;
        read_reg1 = r1; read_reg2 = r2; ab_load = ab; dbg_addr = dbg;
        #1;
    endtask

    task automatic check_comb();
        check("byp_rd1", b_rd1, mread(read_reg1, 1'b1));
        check("byp_rd2", b_rd2, mread(read_reg2, 1'b1));
        check("nob_rd1", n_rd1, mread(read_reg1, 1'b0));
        check("nob_rd2", n_rd2, mread(read_reg2, 1'b0));
        check("byp_dbg", b_dbg, mread(dbg_addr, 1'b0));
        check("nob_dbg", n_dbg, mread(dbg_addr, 1'b0));
    endtask

    // Advance one edge, update the model from pre-edge values, then check the latches.
    task automatic tick();
        logic [31:0] r1b, r2b, r1n, r2n;
        r1b = mread(read_reg1, 1'b1);
        r2b = mread(read_reg2, 1'b1);
        r1n = mread(read_reg1, 1'b0);
        r2n = mread(read_reg2, 1'b0);
        @(posedge clk);
        #1;
        if (reset) begin
            for (int i = 0; i < 32; i++) mem[i] = (i == 29) ? 32'd227 : 32'd0;
            ma_b = 0; mb_b = 0; ma_n = 0; mb_n = 0;
        end else begin
            if (ab_load) begin
                ma_b = r1b; mb_b = r2b; ma_n = r1n; mb_n = r2n;
            end
            if (reg_write && (write_reg % 32 != 0)) mem[write_reg % 32] = write_data;
        end
        check("byp_reg_a", b_a, ma_b);
        check("byp_reg_b", b_b, mb_b);
        check("nob_reg_a", n_a, ma_n);
        check("nob_reg_b", n_b, mb_n);
    endtask

    typedef struct {
        logic        rw;
        logic [31:0] wreg;
        logic [31:0] wd;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic        ab;
        logic [31:0] exp_rd1;  // BYPASS = 1 instance, before the edge
        logic [31:0] exp_rd2;
        logic [31:0] exp_a;    // BYPASS = 1 instance, after the edge
        logic [31:0] exp_b;
    } vec_t;

    vec_t vecs [6];

    initial begin
        vecs[0] = '{1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 5'd8, 5'd29, 1'b0,
                    32'hDEAD_BEEF, 32'd227, 32'd0, 32'd0};
        vecs[1] = '{1'b0, 32'h0, 32'h0, 5'd8, 5'd8, 1'b1,
                    32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[2] = '{1'b1, 32'hFFFF_FFE0, 32'h1234_5678, 5'd0, 5'd8, 1'b1,
                    32'd0, 32'hDEAD_BEEF, 32'd0, 32'hDEAD_BEEF};
        vecs[3] = '{1'b1, 32'hFFFF_FFFF, 32'h1234_5678, 5'd31, 5'd0, 1'b1,
                    32'h1234_5678, 32'd0, 32'h1234_5678, 32'd0};
        vecs[4] = '{1'b1, 32'h0000_0005, 32'h0000_00AA, 5'd5, 5'd5, 1'b1,
                    32'hAA, 32'hAA, 32'hAA, 32'hAA};
        vecs[5] = '{1'b0, 32'h0, 32'h0, 5'd5, 5'd31, 1'b0,
                    32'hAA, 32'h1234_5678, 32'hAA, 32'hAA};

        for (int i = 0; i < 32; i++) mem[i] = 32'd0;
        ma_b = 0; mb_b = 0; ma_n = 0; mb_n = 0;

        // Reset with a competing write to $sp and a latch load: reset must win.
        drive(1'b1, 1'b1, 32'd29, 32'd5, 5'd29, 5'd0, 1'b1, 5'd0);
        tick();

        // Reset contents sweep via the debug port.
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd0, 1'b0, 5'(i));
            check("rst_dbg", b_dbg, (i == 29) ? 32'd227 : 32'd0);
            check("rst_dbg_nob", n_dbg, (i == 29) ? 32'd227 : 32'd0);
        end

        // Directed vector table.
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, vecs[i].rw, vecs[i].wreg, vecs[i].wd, vecs[i].r1, vecs[i].r2,
                  vecs[i].ab, 5'd31);
            check_comb();
            check("tbl_rd1", b_rd1, vecs[i].exp_rd1);
            check("tbl_rd2", b_rd2, vecs[i].exp_rd2);
            tick();
            check("tbl_reg_a", b_a, vecs[i].exp_a);
            check("tbl_reg_b", b_b, vecs[i].exp_b);
        end
        check("dbg_zero_after_write", b_dbg, 32'h1234_5678);

        // Same-cycle write + load without forwarding: BYPASS=0 latches the old value.
        drive(1'b0, 1'b1, 32'd5, 32'h0000_0BBB, 5'd5, 5'd5, 1'b1, 5'd5);
        check_comb();
        check("nob_no_fwd", n_rd1, 32'hAA);
        check("nob_dbg_no_fwd", n_dbg, 32'hAA);
        tick();
        check("nob_old_a", n_a, 32'hAA);
        check("nob_old_b", n_b, 32'hAA);
        check("byp_new_a", b_a, 32'h0BBB);

        // Latch hold: load 7, overwrite the source without ab_load, latch must keep 7.
        drive(1'b0, 1'b1, 32'd3, 32'd7, 5'd0, 5'd0, 1'b0, 5'd3);
        tick();
        drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd3, 5'd3, 1'b1, 5'd3);
        tick();
        check("hold_load", n_a, 32'd7);
        drive(1'b0, 1'b1, 32'd3, 32'd99, 5'd3, 5'd3, 1'b0, 5'd3);
        check_comb();
        tick();
        check("hold_byp_a", b_a, 32'd7);
        check("hold_nob_a", n_a, 32'd7);
        drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd3, 5'd3, 1'b1, 5'd3);
        tick();
        check("reload_a", n_a, 32'd99);

        // Randomised traffic against the model, with occasional resets.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] wr;
            logic [4:0]  r1, r2;
            wr = $urandom;
            r1 = ($urandom_range(0, 3) == 0) ? wr[4:0] : 5'($urandom);
            r2 = ($urandom_range(0, 3) == 0) ? wr[4:0] : 5'($urandom);
            drive(($urandom_range(0, 49) == 0), 1'($urandom), wr, $urandom, r1, r2,
                  1'($urandom), 5'($urandom));
            check_comb();
            tick();
        end

        // Reset discards a pending write, including to $sp.
        drive(1'b1, 1'b1, 32'd29, 32'd5, 5'd29, 5'd29, 1'b1, 5'd29);
        tick();
        drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd29, 5'd29, 1'b0, 5'd29);
        check("rst_vs_write_sp", b_dbg, 32'd227);
        check("rst_vs_write_rd", n_rd1, 32'd227);
        check_comb();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
